// File: rtl/quad_pkg.sv
// ----------------------------------------------------------------------------
// quad_pkg
// Shared types and helpers for the quadrature decoder:
//   fsm_state_t   - decoder control state (INIT while synchronisers fill, RUN)
//   quad_state_t  - 2-bit Gray state {a, b}
//   up_next()     - up-direction successor of a Gray state
// ----------------------------------------------------------------------------
package quad_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } fsm_state_t;

    typedef logic [1:0] quad_state_t;

    // Edges spent in INIT before the synchroniser output is trusted.
    localparam logic [1:0] INIT_FILL = 2'd2;

    // Up sequence: 00 -> 01 -> 11 -> 10 -> 00
    function automatic quad_state_t up_next(input quad_state_t s);
        quad_state_t n;
        case (s)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            2'b10:   n = 2'b00;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// ----------------------------------------------------------------------------
// quad_decoder_if
// Encoder pins, error clear and decoder results.
//   qa, qb, err_clr         : driven by master (board / testbench)
//   step, is_up, err, count : driven by slave (quad_decoder)
// ----------------------------------------------------------------------------
interface quad_decoder_if #(
    parameter int WIDTH = 8
);
    logic             qa;
    logic             qb;
    logic             err_clr;
    logic             step;
    logic             is_up;
    logic             err;
    logic [WIDTH-1:0] count;

    modport master (
        output qa, qb, err_clr,
        input  step, is_up, err, count
    );

    modport slave (
        input  qa, qb, err_clr,
        output step, is_up, err, count
    );
endinterface

// File: rtl/quad_filter.sv
// ----------------------------------------------------------------------------
// quad_filter
// Two-flop synchroniser plus glitch filter for one encoder channel.
//   clk, rst : clock, async active-high reset
//   i_in     : raw asynchronous channel
//   i_load   : force filtered level to the synchroniser output (used in INIT)
//   o_sync   : synchronised channel
//   o_filt   : filtered channel
// ----------------------------------------------------------------------------
module quad_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_in,
    input  logic i_load,
    output logic o_sync,
    output logic o_filt
);
    // Counter value on the cycle the new level is accepted.
    localparam logic [7:0] LP_LAST = 8'(FILTER_LEN - 1);

    logic       r_s1;
    logic       r_s2;
    logic       r_filt;
    logic [7:0] r_cnt;

    // Two-flop synchroniser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_in;
            r_s2 <= r_s1;
        end
    end

    // Glitch filter: accept a new level only after FILTER_LEN differing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt <= 1'b0;
            r_cnt  <= 8'd0;
        end else if (i_load) begin
            r_filt <= r_s2;
            r_cnt  <= 8'd0;
        end else if (r_s2 == r_filt) begin
            r_cnt  <= 8'd0;
        end else if (r_cnt == LP_LAST) begin
            r_filt <= r_s2;
            r_cnt  <= 8'd0;
        end else begin
            r_cnt  <= r_cnt + 8'd1;
        end
    end

    assign o_sync = r_s2;
    assign o_filt = r_filt;
endmodule

// File: rtl/quad_decoder.sv
// ----------------------------------------------------------------------------
// quad_decoder
// Quadrature decoder: filters A/B, decodes Gray transitions into step pulses
// with direction, keeps a wrapping position count and a sticky error flag.
//   clk, rst : clock, async active-high reset
//   bus      : quad_decoder_if.slave (qa, qb, err_clr in; step, is_up, err,
//              count out)
// ----------------------------------------------------------------------------
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FILTER_LEN = 4
) (
    input  logic            clk,
    input  logic            rst,
    quad_decoder_if.slave   bus
);
    fsm_state_t       r_state;
    logic [1:0]       r_init_cnt;
    quad_state_t      r_prev;
    logic             r_step;
    logic             r_is_up;
    logic             r_err;
    logic [WIDTH-1:0] r_count;

    logic             w_load;
    logic             w_sync_a;
    logic             w_sync_b;
    logic             w_filt_a;
    logic             w_filt_b;
    quad_state_t      w_cur;
    logic             w_up;
    logic             w_down;
    logic             w_illegal;

    // While in INIT the filters track the synchroniser so the levels present
    // at reset release are adopted without producing a transition.
    assign w_load = (r_state == ST_INIT);

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk    (clk),
        .rst    (rst),
        .i_in   (bus.qa),
        .i_load (w_load),
        .o_sync (w_sync_a),
        .o_filt (w_filt_a)
    );

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk    (clk),
        .rst    (rst),
        .i_in   (bus.qb),
        .i_load (w_load),
        .o_sync (w_sync_b),
        .o_filt (w_filt_b)
    );

    assign w_cur = {w_filt_a, w_filt_b};

    // Control FSM: wait for the synchroniser to fill, then decode forever.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= 2'd0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == INIT_FILL) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_init_cnt <= r_init_cnt + 2'd1;
                    end
                end
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Previous filtered state; in INIT it follows the value being loaded into
    // the filters so the first RUN cycle sees no change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 2'b00;
        end else if (w_load) begin
            r_prev <= {w_sync_a, w_sync_b};
        end else begin
            r_prev <= w_cur;
        end
    end

    // Transition classification: up, down, or both bits changed.
    always_comb begin
        w_up      = 1'b0;
        w_down    = 1'b0;
        w_illegal = 1'b0;
        if (r_state != ST_RUN || w_cur == r_prev) begin
            w_up = 1'b0;
        end else if (w_cur == up_next(r_prev)) begin
            w_up = 1'b1;
        end else if (r_prev == up_next(w_cur)) begin
            w_down = 1'b1;
        end else begin
            w_illegal = 1'b1;
        end
    end

    // Registered step, direction and position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step  <= 1'b0;
            r_is_up <= 1'b1;
            r_count <= '0;
        end else begin
            r_step <= w_up | w_down;
            if (w_up) begin
                r_is_up <= 1'b1;
                r_count <= r_count + WIDTH'(1);
            end else if (w_down) begin
                r_is_up <= 1'b0;
                r_count <= r_count - WIDTH'(1);
            end else begin
                r_is_up <= r_is_up;
                r_count <= r_count;
            end
        end
    end

    // Sticky error; a new illegal transition beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
        end else if (bus.err_clr) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err;
        end
    end

    assign bus.step  = r_step;
    assign bus.is_up = r_is_up;
    assign bus.err   = r_err;
    assign bus.count = r_count;
endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   step_cnt = 0;

    // Reference model: position along the Gray cycle, expected outputs.
    int   m_count = 0;
    bit   m_up    = 1'b1;
    bit   m_err   = 1'b0;
    int   m_idx   = 0;
    int   m_steps = 0;

    quad_decoder_if #(.WIDTH(8)) bus ();

    quad_decoder #(.WIDTH(8), .FILTER_LEN(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.step === 1'b1) step_cnt <= step_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Position of a Gray state in the up cycle 00,01,11,10.
    function automatic int gidx(input bit a, input bit b);
        return int'({a, a ^ b});
    endfunction

    task automatic model_move(input bit a, input bit b);
        int d;
        d = (gidx(a, b) - m_idx + 4) % 4;
        m_steps = 0;
        if (d == 1) begin
            m_count = (m_count + 1) % 256; m_up = 1'b1; m_steps = 1;
        end else if (d == 3) begin
            m_count = (m_count + 255) % 256; m_up = 1'b0; m_steps = 1;
        end else if (d == 2) begin
            m_err = 1'b1;
        end
        m_idx = gidx(a, b);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_count"}, 32'(bus.count), 32'(m_count));
        chk({tag, "_is_up"}, 32'(bus.is_up), 32'(m_up));
        chk({tag, "_err"},   32'(bus.err),   32'(m_err));
    endtask

    task automatic move(input string tag, input bit a, input bit b, input int hold);
        int s0;
        s0 = step_cnt;
        model_move(a, b);
        @(negedge clk);
        bus.qa = a; bus.qb = b;
        repeat (hold) @(negedge clk);
        check_outputs(tag);
        chk({tag, "_steps"}, 32'(step_cnt - s0), 32'(m_steps));
    endtask

    task automatic do_reset(input bit a, input bit b);
        int s0;
        @(negedge clk);
        rst = 1'b1; bus.qa = a; bus.qb = b;
        #1;
        m_count = 0; m_up = 1'b1; m_err = 1'b0; m_idx = gidx(a, b);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_is_up", 32'(bus.is_up), 32'd1);
        chk("rst_step",  32'(bus.step),  32'd0);
        chk("rst_err",   32'(bus.err),   32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        s0 = step_cnt;
        repeat (12) @(negedge clk);
        chk("rel_steps", 32'(step_cnt - s0), 32'd0);
        check_outputs("rel");
    endtask

    task automatic clear_err();
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        m_err = 1'b0;
        chk("clr_err", 32'(bus.err), 32'd0);
    endtask

    initial begin
        int s0;
        bus.qa = 1'b0; bus.qb = 1'b0; bus.err_clr = 1'b0;

        // Reset and forward sweep
        do_reset(1'b0, 1'b0);
        s0 = step_cnt;
        move("fwd1", 1'b0, 1'b1, 10);
        move("fwd2", 1'b1, 1'b1, 10);
        move("fwd3", 1'b1, 1'b0, 10);
        move("fwd4", 1'b0, 1'b0, 10);
        chk("fwd_total", 32'(step_cnt - s0), 32'd4);
        chk("fwd_count", 32'(bus.count), 32'd4);

        // Reverse from zero with latency check
        do_reset(1'b0, 1'b0);
        s0 = step_cnt;
        model_move(1'b1, 1'b0);
        @(negedge clk);
        bus.qa = 1'b1; bus.qb = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("rev_early_step", 32'(bus.step), 32'd0);
        @(posedge clk);
        #1 chk("rev_step", 32'(bus.step), 32'd1);
        check_outputs("rev");
        @(posedge clk);
        #1 chk("rev_step_end", 32'(bus.step), 32'd0);
        chk("rev_total", 32'(step_cnt - s0), 32'd1);
        move("rev_back", 1'b0, 1'b0, 10);

        // Glitch shorter than the filter
        s0 = step_cnt;
        @(negedge clk);
        bus.qa = 1'b1;
        repeat (3) @(negedge clk);
        bus.qa = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_steps", 32'(step_cnt - s0), 32'd0);
        check_outputs("glitch");

        // Long pulse: down then up
        s0 = step_cnt;
        move("pulse_dn", 1'b1, 1'b0, 12);
        move("pulse_up", 1'b0, 1'b0, 10);
        chk("pulse_total", 32'(step_cnt - s0), 32'd2);

        // Illegal transition, clear, then clear coincident with illegal
        move("illegal", 1'b1, 1'b1, 10);
        clear_err();
        s0 = step_cnt;
        model_move(1'b0, 1'b0);
        @(negedge clk);
        bus.qa = 1'b0; bus.qb = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.err_clr = 1'b1;
        @(posedge clk);
        #1 bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("ill_clr");
        chk("ill_clr_steps", 32'(step_cnt - s0), 32'd0);
        clear_err();

        // Randomised walk, including illegal moves and no-change
        for (int i = 0; i < 60; i++) begin
            logic [1:0] t;
            t = 2'($urandom_range(0, 3));
            move("rnd", t[1], t[1] ^ t[0], $urandom_range(8, 14));
            if (m_err && ($urandom_range(0, 3) == 0)) clear_err();
        end

        // Reset mid-operation at count 5 with both channels high
        do_reset(1'b0, 1'b1);
        move("mid1", 1'b1, 1'b1, 10);
        move("mid2", 1'b1, 1'b0, 10);
        move("mid3", 1'b0, 1'b0, 10);
        move("mid4", 1'b0, 1'b1, 10);
        move("mid5", 1'b1, 1'b1, 10);
        chk("mid_count5", 32'(bus.count), 32'd5);
        do_reset(1'b1, 1'b1);
        move("mid_after", 1'b1, 1'b0, 10);
        chk("mid_count1", 32'(bus.count), 32'd1);

        // Wrap: 256 forward transitions from zero
        do_reset(1'b0, 1'b0);
        s0 = step_cnt;
        for (int i = 0; i < 256; i++) begin
            int n;
            n = (m_idx + 1) % 4;
            move("wrap", n[1], n[1] ^ n[0], 8);
        end
        chk("wrap_count", 32'(bus.count), 32'd0);
        chk("wrap_steps", 32'(step_cnt - s0), 32'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature input decoder that generates the step/direction stimulus consumed by the up/down counter, and keeps its own position count. It sits between the two-channel encoder pins (A/B) on the board and the counter logic. Each channel passes through a two-flop synchroniser and a glitch filter, and the filtered 2-bit Gray state is decoded into single-cycle step pulses with a direction flag.

## Interface
- `WIDTH`, 8: position counter width.
- `FILTER_LEN`, 4: consecutive cycles a synchronised input must differ from its filtered value before the new level is accepted; legal range 1..255.

- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `qa`  in  1  encoder channel A, asynchronous to `clk`.
- `qb`  in  1  encoder channel B, asynchronous to `clk`.
- `err_clr`  in  1  synchronous clear of sticky `err`.
- `step`  out  1  one-cycle pulse per valid quadrature transition.
- `is_up`  out  1  direction of the last valid transition (1 = up).
- `err`  out  1  sticky flag: an illegal transition was seen.
- `count`  out  WIDTH  position, modulo 2^WIDTH.

## Operation
- Reset values: `step`=0, `is_up`=1, `err`=0, `count`=0. The synchroniser flops, filtered levels and filter counters all reset to 0.
- **Synchroniser:** two flops per channel.
- **Filter, per channel:**
  - If the synchronised value equals the filtered value, the counter clears.
  - Otherwise the counter increments. When it reaches `FILTER_LEN`, the filtered value takes the synchronised value and the counter clears.
  - A pulse shorter than `FILTER_LEN` cycles is discarded.
- **FSM states:**
  - INIT: entered on reset. Lasts 2 cycles so the synchroniser can fill. On leaving, the filtered values are loaded directly from the synchroniser outputs. No `step` and no `err` are produced in INIT. Then go to RUN.
  - RUN: decode state. It is never left except by reset.
- **Decode in RUN**, state = {a_f, b_f}, comparing the previous state with the new one:
  - Up sequence is 00→01→11→10→00. An up move gives `step`=1, `is_up`=1, `count`+1; 2^WIDTH−1 wraps to 0.
  - The reverse sequence gives `step`=1, `is_up`=0, `count`−1; 0 wraps to 2^WIDTH−1.
  - Both bits changing in one cycle is illegal: `err` is set, `step`=0, `count` and `is_up` are unchanged.
  - No change: `step`=0 and all outputs hold.
- **`err` behaviour:** `err_clr` clears `err`. If `err_clr` and an illegal transition occur in the same cycle, `err` stays 1 (set wins).
- **Reset mid-operation:** all state returns to reset values immediately, and the FSM re-enters INIT. Input levels present at release are adopted silently, with no step and no error.

## Timing
- Input edge to filtered update: 2 + `FILTER_LEN` clock edges, with the input stable before edge 1.
- `step`, `is_up`, `count` and `err` are registered. They update on the edge after the filtered update, so total latency is 3 + `FILTER_LEN` edges.
- `step` is high for exactly one cycle per transition.
- Back-to-back transitions are each decoded. Minimum spacing per channel is `FILTER_LEN` cycles.
- `count` and `step` change on the same edge.

## Structure
- Package `quad_pkg` holds:
  - the FSM state typedef (INIT, RUN);
  - a 2-bit quadrature state typedef;
  - a function returning the up-successor of a Gray state.
- Sub-module `quad_filter` contains the synchroniser and glitch filter for one channel, parameterised by `FILTER_LEN`. It is instantiated twice.
- The top level holds the FSM, the decode, the counter and the error flag.

## Test plan
- **Forward sweep:** `FILTER_LEN`=4, start qa=qb=0, release `rst`, apply transitions 00→01→11→10→00 spaced 10 cycles → four `step` pulses, `is_up`=1, `count`=4, `err`=0.
- **Reverse from zero:** from count 0, apply one 00→10 transition → `count`=255, `is_up`=0, `step` pulse 7 edges after the input edge.
- **Glitch filtering:**
  - qa high for 3 cycles → no `step`, `count` unchanged.
  - qa high for 12 cycles → two steps (down then up), net `count` unchanged, final `is_up`=1.
- **Illegal transition:** qa and qb toggled on the same clock → `err`=1, no `step`, `count` unchanged. Pulse `err_clr` → `err`=0. Repeat with `err_clr` coincident with an illegal transition → `err` remains 1.
- **Reset mid-operation:** at `count`=5 with qa=qb=1 held, assert `rst` → `count`=0, `is_up`=1. After release: no `step`, no `err`. A following 11→10 transition gives `count`=1.
- **Wrap:** 256 forward transitions from 0 → `count`=0, 256 `step` pulses.
